escape_parser: RTL and testbench



---
 rtl/escape_parser_if.sv | 23 ++
 rtl/escape_parser.sv | 187 ++++++++++++++++++
 tb/tb_escape_parser.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/escape_parser_if.sv
// Byte-stream and command/character bundle between the receive source and the escape parser.
// The master side drives bytes in; the slave side (the parser) returns decoded commands and characters.
interface escape_parser_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       cmd_valid;
  logic [3:0] cmd_type;
  logic [7:0] cmd_pn1;
  logic [7:0] cmd_pn2;
  logic       char_valid;
  logic [7:0] char_data;
  logic       busy;

  modport master (
    output in_valid, in_data,
    input  cmd_valid, cmd_type, cmd_pn1, cmd_pn2, char_valid, char_data, busy
  );

  modport slave (
    input  in_valid, in_data,
    output cmd_valid, cmd_type, cmd_pn1, cmd_pn2, char_valid, char_data, busy
  );
endinterface

// File: rtl/escape_parser.sv
// VT100/ANSI escape parser: splits a byte stream into printable characters and cursor commands.
// Optional macro ESCAPE_PARSER_C0_EN enables LF/VT -> IND and CAN/SUB abort handling.
module escape_parser #(
  parameter int PARAM_MAX = 255
) (
  input logic          clk,
  input logic          rst,
  escape_parser_if.slave bus
);

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_CUP  = 4'd1;
  localparam logic [3:0] CMD_CUF  = 4'd2;
  localparam logic [3:0] CMD_CUB  = 4'd3;
  localparam logic [3:0] CMD_CUD  = 4'd4;
  localparam logic [3:0] CMD_CUU  = 4'd5;
  localparam logic [3:0] CMD_IND  = 4'd6;
  localparam logic [3:0] CMD_RI   = 4'd7;
  localparam logic [3:0] CMD_NEL  = 4'd8;
  localparam logic [11:0] SAT12   = 12'(PARAM_MAX);
  localparam logic [7:0]  SAT8    = 8'(PARAM_MAX);

  typedef enum logic [1:0] {GROUND, ESC, CSI_PARAM, CSI_IGNORE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pn1_reg, pn1_next, pn2_reg, pn2_next;
  logic [1:0] idx_reg, idx_next;
  logic       first_reg, first_next;
  logic       cmd_valid_reg, cmd_valid_next;
  logic [3:0] cmd_type_reg, cmd_type_next;
  logic [7:0] cmd_pn1_reg, cmd_pn1_next, cmd_pn2_reg, cmd_pn2_next;
  logic       char_valid_reg, char_valid_next;
  logic [7:0] char_data_reg, char_data_next;
  logic       busy_reg;

  logic [7:0]  byte_in;
  logic        is_c0, is_digit, is_final;
  logic [7:0]  acc_sel;
  logic [11:0] acc_calc;
  logic [7:0]  acc_sat;

  assign byte_in  = bus.in_data;
  assign is_c0    = (byte_in < 8'h20) && (byte_in != 8'h1B);
  assign is_digit = (byte_in >= 8'h30) && (byte_in <= 8'h39);
  assign is_final = (byte_in >= 8'h40) && (byte_in <= 8'h7E);
  assign acc_sel  = (idx_reg == 2'd0) ? pn1_reg : pn2_reg;
  // 12-bit headroom: 255*10+9 fits, so the clamp sees the true value
  assign acc_calc = {4'd0, acc_sel} * 12'd10 + {8'd0, byte_in[3:0]};
  assign acc_sat  = (acc_calc > SAT12) ? SAT8 : acc_calc[7:0];

  always_comb begin
    state_next      = state_reg;
    pn1_next        = pn1_reg;
    pn2_next        = pn2_reg;
    idx_next        = idx_reg;
    first_next      = first_reg;
    cmd_valid_next  = 1'b0;
    cmd_type_next   = cmd_type_reg;
    cmd_pn1_next    = cmd_pn1_reg;
    cmd_pn2_next    = cmd_pn2_reg;
    char_valid_next = 1'b0;
    char_data_next  = char_data_reg;

    if (bus.in_valid) begin
      if (is_c0) begin
`ifdef ESCAPE_PARSER_C0_EN
        if (byte_in == 8'h18 || byte_in == 8'h1A) begin
          state_next = GROUND;
        end else if (state_reg == GROUND && (byte_in == 8'h0A || byte_in == 8'h0B)) begin
          cmd_valid_next = 1'b1;
          cmd_type_next  = CMD_IND;
          cmd_pn1_next   = 8'd0;
          cmd_pn2_next   = 8'd0;
        end
`endif
      end else begin
        case (state_reg)
          GROUND: begin
            if (byte_in == 8'h1B) begin
              state_next = ESC;
            end else if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
              char_valid_next = 1'b1;
              char_data_next  = byte_in;
            end
          end
          ESC: begin
            state_next = GROUND;
            case (byte_in)
              8'h5B: begin
                state_next = CSI_PARAM;
                pn1_next   = 8'd0;
                pn2_next   = 8'd0;
                idx_next   = 2'd0;
                first_next = 1'b1;
              end
              8'h44, 8'h4D, 8'h45: begin
                cmd_valid_next = 1'b1;
                cmd_type_next  = (byte_in == 8'h44) ? CMD_IND :
                                 (byte_in == 8'h4D) ? CMD_RI : CMD_NEL;
                cmd_pn1_next   = 8'd0;
                cmd_pn2_next   = 8'd0;
              end
              8'h1B:   state_next = ESC;
              default: state_next = GROUND;
            endcase
          end
          CSI_PARAM: begin
            first_next = 1'b0;
            if (byte_in == 8'h1B) begin
              state_next = ESC;
            end else if (is_digit) begin
              if (idx_reg == 2'd0)      pn1_next = acc_sat;
              else if (idx_reg == 2'd1) pn2_next = acc_sat;
            end else if (byte_in == 8'h3B) begin
              if (idx_reg != 2'd2) idx_next = idx_reg + 2'd1;
            end else if (first_reg && byte_in >= 8'h3C && byte_in <= 8'h3F) begin
              state_next = CSI_IGNORE;
            end else if (byte_in >= 8'h20 && byte_in <= 8'h2F) begin
              state_next = CSI_IGNORE;
            end else if (is_final) begin
              state_next   = GROUND;
              cmd_pn1_next = pn1_reg;
              cmd_pn2_next = pn2_reg;
              cmd_valid_next = 1'b1;
              case (byte_in)
                8'h48, 8'h66: cmd_type_next = CMD_CUP;
                8'h41:        cmd_type_next = CMD_CUU;
                8'h42:        cmd_type_next = CMD_CUD;
                8'h43:        cmd_type_next = CMD_CUF;
                8'h44:        cmd_type_next = CMD_CUB;
                default: begin
                  cmd_valid_next = 1'b0;
                  cmd_pn1_next   = cmd_pn1_reg;
                  cmd_pn2_next   = cmd_pn2_reg;
                end
              endcase
            end
          end
          CSI_IGNORE: begin
            if (byte_in == 8'h1B)  state_next = ESC;
            else if (is_final)     state_next = GROUND;
          end
          default: state_next = GROUND;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= GROUND;
      pn1_reg        <= 8'd0;
      pn2_reg        <= 8'd0;
      idx_reg        <= 2'd0;
      first_reg      <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      cmd_type_reg   <= CMD_NONE;
      cmd_pn1_reg    <= 8'd0;
      cmd_pn2_reg    <= 8'd0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= 8'd0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pn1_reg        <= pn1_next;
      pn2_reg        <= pn2_next;
      idx_reg        <= idx_next;
      first_reg      <= first_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_type_reg   <= cmd_type_next;
      cmd_pn1_reg    <= cmd_pn1_next;
      cmd_pn2_reg    <= cmd_pn2_next;
      char_valid_reg <= char_valid_next;
      char_data_reg  <= char_data_next;
      busy_reg       <= (state_next != GROUND);
    end
  end

  assign bus.cmd_valid  = cmd_valid_reg;
  assign bus.cmd_type   = cmd_type_reg;
  assign bus.cmd_pn1    = cmd_pn1_reg;
  assign bus.cmd_pn2    = cmd_pn2_reg;
  assign bus.char_valid = char_valid_reg;
  assign bus.char_data  = char_data_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_escape_parser.sv
// Self-checking bench for escape_parser: byte-vector table plus hand sequences for reset abort,
// idle-cycle freeze and output hold.
module tb_escape_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  escape_parser_if bus();

  escape_parser #(.PARAM_MAX(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         exp_cmd;
    logic [3:0] exp_type;
    logic [7:0] exp_pn1;
    logic [7:0] exp_pn2;
    bit         exp_char;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] d, input bit c, input logic [3:0] t,
                              input logic [7:0] p1, input logic [7:0] p2,
                              input bit ch, input bit bsy);
    vec_t v;
    v.data = d; v.exp_cmd = c; v.exp_type = t; v.exp_pn1 = p1; v.exp_pn2 = p2;
    v.exp_char = ch; v.exp_busy = bsy;
    vecs.push_back(v);
  endfunction

  function automatic void none(input logic [7:0] d, input bit bsy);
    add(d, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0, bsy);
  endfunction

  function automatic void chr(input logic [7:0] d);
    add(d, 1'b0, 4'd0, 8'd0, 8'd0, 1'b1, 1'b0);
  endfunction

  function automatic void cmd(input logic [7:0] d, input logic [3:0] t,
                              input logic [7:0] p1, input logic [7:0] p2);
    add(d, 1'b1, t, p1, p2, 1'b0, 1'b0);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("reset_cmd_type", 32'(bus.cmd_type), 32'd0);
    chk("reset_pn1", 32'(bus.cmd_pn1), 32'd0);
    chk("reset_pn2", 32'(bus.cmd_pn2), 32'd0);
    chk("reset_char_valid", 32'(bus.char_valid), 32'd0);
    chk("reset_char_data", 32'(bus.char_data), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CUP 12;40
    none(8'h1B,1); none(8'h5B,1); none(8'h31,1); none(8'h32,1);
    none(8'h3B,1); none(8'h34,1); none(8'h30,1); cmd(8'h48, 4'd1, 8'd12, 8'd40);
    // CUF with omitted parameters
    none(8'h1B,1); none(8'h5B,1); cmd(8'h43, 4'd2, 8'd0, 8'd0);
    // CUU with saturated 999
    none(8'h1B,1); none(8'h5B,1); none(8'h39,1); none(8'h39,1); none(8'h39,1);
    cmd(8'h41, 4'd5, 8'd255, 8'd0);
    // IND, RI, NEL back to back
    none(8'h1B,1); cmd(8'h44, 4'd6, 8'd0, 8'd0);
    none(8'h1B,1); cmd(8'h4D, 4'd7, 8'd0, 8'd0);
    none(8'h1B,1); cmd(8'h45, 4'd8, 8'd0, 8'd0);
    // unknown ESC final
    none(8'h1B,1); none(8'h5A,0);
    // char, private sequence, char
    chr(8'h41); none(8'h1B,1); none(8'h5B,1); none(8'h3F,1); none(8'h32,1);
    none(8'h35,1); none(8'h6C,0); chr(8'h42);
    // clamp boundary: 255 exact and 256 clamped
    none(8'h1B,1); none(8'h5B,1); none(8'h32,1); none(8'h35,1); none(8'h35,1);
    none(8'h3B,1); none(8'h32,1); none(8'h35,1); none(8'h36,1);
    cmd(8'h48, 4'd1, 8'd255, 8'd255);
    // third parameter discarded, 'f' final
    none(8'h1B,1); none(8'h5B,1); none(8'h37,1); none(8'h3B,1); none(8'h38,1);
    none(8'h3B,1); none(8'h39,1); cmd(8'h66, 4'd1, 8'd7, 8'd8);
    // CUB with parameter
    none(8'h1B,1); none(8'h5B,1); none(8'h33,1); cmd(8'h44, 4'd3, 8'd3, 8'd0);
    // ESC restarts a CSI
    none(8'h1B,1); none(8'h5B,1); none(8'h35,1); none(8'h1B,1); cmd(8'h4D, 4'd7, 8'd0, 8'd0);
    // ESC ESC stays in ESC
    none(8'h1B,1); none(8'h1B,1); cmd(8'h45, 4'd8, 8'd0, 8'd0);
    // intermediate byte -> ignore, then a plain char
    none(8'h1B,1); none(8'h5B,1); none(8'h20,1); none(8'h48,0); chr(8'h5A);
    // DEL ignored in ground; CR inside ESC ignored
    none(8'h7F,0); none(8'h1B,1); none(8'h0D,1); cmd(8'h44, 4'd6, 8'd0, 8'd0);
`ifdef ESCAPE_PARSER_C0_EN
    cmd(8'h0A, 4'd6, 8'd0, 8'd0);
    none(8'h1B,1); none(8'h5B,1); none(8'h33,1); none(8'h18,0); chr(8'h48);
`else
    none(8'h0A,0);
    none(8'h1B,1); none(8'h5B,1); none(8'h33,1); none(8'h18,1);
    cmd(8'h48, 4'd1, 8'd3, 8'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].data);
      $display("vec %0d: byte=%02h cmd_valid=%0b type=%0d pn1=%0d pn2=%0d char_valid=%0b char=%02h busy=%0b",
               i, vecs[i].data, bus.cmd_valid, bus.cmd_type, bus.cmd_pn1, bus.cmd_pn2,
               bus.char_valid, bus.char_data, bus.busy);
      chk($sformatf("vec%0d_cmd_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].exp_cmd));
      chk($sformatf("vec%0d_char_valid", i), 32'(bus.char_valid), 32'(vecs[i].exp_char));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_cmd) begin
        chk($sformatf("vec%0d_cmd_type", i), 32'(bus.cmd_type), 32'(vecs[i].exp_type));
        chk($sformatf("vec%0d_pn1", i), 32'(bus.cmd_pn1), 32'(vecs[i].exp_pn1));
        chk($sformatf("vec%0d_pn2", i), 32'(bus.cmd_pn2), 32'(vecs[i].exp_pn2));
      end
      if (vecs[i].exp_char)
        chk($sformatf("vec%0d_char_data", i), 32'(bus.char_data), 32'(vecs[i].data));
    end

    // reset in the middle of a CSI aborts it
    send(8'h1B); send(8'h5B); send(8'h35);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("abort: rst cycle cmd_valid=%0b busy=%0b", bus.cmd_valid, bus.busy);
    chk("abort_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cmd_type", 32'(bus.cmd_type), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h48);
    $display("abort: byte=48 cmd_valid=%0b char_valid=%0b char=%02h", bus.cmd_valid, bus.char_valid, bus.char_data);
    chk("abort_after_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("abort_after_char_valid", 32'(bus.char_valid), 32'd1);
    chk("abort_after_char_data", 32'(bus.char_data), 32'h48);

    // idle cycles freeze the parse; outputs hold after the pulse
    send(8'h1B); idle(); idle();
    chk("freeze_busy", 32'(bus.busy), 32'd1);
    chk("freeze_char_valid", 32'(bus.char_valid), 32'd0);
    send(8'h5B); idle();
    send(8'h34); idle();
    chk("freeze_cmd_valid_idle", 32'(bus.cmd_valid), 32'd0);
    send(8'h42);
    $display("freeze: byte=42 cmd_valid=%0b type=%0d pn1=%0d busy=%0b", bus.cmd_valid, bus.cmd_type, bus.cmd_pn1, bus.busy);
    chk("freeze_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    chk("freeze_cmd_type", 32'(bus.cmd_type), 32'd4);
    chk("freeze_pn1", 32'(bus.cmd_pn1), 32'd4);
    idle();
    $display("hold: cmd_valid=%0b type=%0d pn1=%0d char=%02h", bus.cmd_valid, bus.cmd_type, bus.cmd_pn1, bus.char_data);
    chk("hold_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("hold_cmd_type", 32'(bus.cmd_type), 32'd4);
    chk("hold_pn1", 32'(bus.cmd_pn1), 32'd4);
    chk("hold_char_data", 32'(bus.char_data), 32'h48);
    chk("hold_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
